// File: rtl/ddr3_app_pkg.sv
// Shared command codes, default bus widths and executor states for the DDR3 app-interface responder.
// Pure definitions: no logic, no latency, no flow control.
package ddr3_app_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   localparam int DEF_DATA_W = 256;
   localparam int DEF_ADDR_W = 29;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_REFRESH
   } exec_state_e;

   function automatic logic cmd_legal(input logic [2:0] c);
      return (c == CMD_WR) || (c == CMD_RD);
   endfunction

endpackage

// File: rtl/app_sync_fifo.sv
// Single-clock FIFO with first-word fall-through output; push-to-visible latency one cycle.
// Caller must not push when full or pop when empty; simultaneous push and pop on full is legal.
module app_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i)
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop_i)
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (push_i && !pop_i)
         cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push_i)
         mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ddr3_app_responder.sv
// BRAM-backed stand-in for a DDR3 controller app port; reads return RD_LAT cycles after execution.
// cmd_ready drops on calibration, full command FIFO or refresh stall; wr_data_rdy drops on calibration or full data FIFO.
module ddr3_app_responder
   import ddr3_app_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int MEM_AW       = 10,
   parameter int CALIB_CYCLES = 64,
   parameter int RD_LAT       = 6,
   parameter int REF_INTERVAL = 780,
   parameter int REF_CYCLES   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          cmd,
   input  logic                cmd_en,
   input  logic [ADDR_W-1:0]   addr,
   output logic                cmd_ready,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                wr_data_en,
   input  logic                wr_data_end,
   input  logic [DATA_W/8-1:0] wr_data_mask,
   output logic                wr_data_rdy,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_data_valid,
   output logic                rd_data_end,
   input  logic                ref_req,
   output logic                ref_ack,
   output logic                init_calib_complete,
   output logic                err_illegal
);

   localparam int BE_W = DATA_W / 8;
   localparam int CCW  = $clog2(CALIB_CYCLES + 1);
   localparam int TW   = $clog2(REF_INTERVAL + 1);
   localparam int SW   = $clog2(REF_CYCLES + 1);

   logic [CCW-1:0] cal_cnt_q;
   logic           calib_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cal_cnt_q <= '0;
         calib_q   <= 1'b0;
      end else if (!calib_q) begin
         cal_cnt_q <= cal_cnt_q + CCW'(1);
         if (cal_cnt_q == CCW'(CALIB_CYCLES - 1))
            calib_q <= 1'b1;
      end
   end

   exec_state_e state_q;
   logic        cq_full, cq_empty, cq_pop, cq_push;
   logic        dq_full, dq_empty, dq_pop, dq_push;
   logic [ADDR_W+2:0]      cq_dout;
   logic [DATA_W+BE_W-1:0] dq_dout;
   logic [2:0]             cq_cmd;
   logic [ADDR_W-1:0]      cq_addr;
   logic [DATA_W-1:0]      dq_data;
   logic [BE_W-1:0]        dq_mask;

   assign cmd_ready   = calib_q && !cq_full && (state_q != ST_REFRESH);
   assign wr_data_rdy = calib_q && !dq_full;
   assign cq_push     = cmd_en && cmd_ready;
   assign dq_push     = wr_data_en && wr_data_rdy;

   app_sync_fifo #(.W(ADDR_W + 3), .DEPTH(4)) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (cq_push),
      .din_i   ({cmd, addr}),
      .pop_i   (cq_pop),
      .dout_o  (cq_dout),
      .full_o  (cq_full),
      .empty_o (cq_empty)
   );

   app_sync_fifo #(.W(DATA_W + BE_W), .DEPTH(4)) u_wdata_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (dq_push),
      .din_i   ({wr_data, wr_data_mask}),
      .pop_i   (dq_pop),
      .dout_o  (dq_dout),
      .full_o  (dq_full),
      .empty_o (dq_empty)
   );

   assign cq_cmd  = cq_dout[ADDR_W+2:ADDR_W];
   assign cq_addr = cq_dout[ADDR_W-1:0];
   assign dq_data = dq_dout[DATA_W+BE_W-1:BE_W];
   assign dq_mask = dq_dout[BE_W-1:0];

   logic                ref_pend_q, ref_user_q, ref_ack_q, err_q;
   logic [SW-1:0]       ref_cnt_q;
   logic [TW-1:0]       ref_tmr_q;
   logic                is_wr, is_rd, exec_fire, rd_launch;
   logic [MEM_AW-1:0]   mem_idx;

   assign is_wr     = (cq_cmd == CMD_WR);
   assign is_rd     = (cq_cmd == CMD_RD);
   // A pending refresh blocks execution so the FSM can move to REFRESH next cycle.
   assign exec_fire = (state_q == ST_EXEC) && !ref_pend_q && !cq_empty && (!is_wr || !dq_empty);
   assign cq_pop    = exec_fire;
   assign dq_pop    = exec_fire && is_wr;
   assign rd_launch = exec_fire && is_rd;
   assign mem_idx   = cq_addr[MEM_AW+2:3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ref_cnt_q  <= '0;
         ref_tmr_q  <= TW'(REF_INTERVAL);
         ref_pend_q <= 1'b0;
         ref_user_q <= 1'b0;
         ref_ack_q  <= 1'b0;
      end else begin
         ref_ack_q <= 1'b0;
         if (calib_q && ref_tmr_q != '0)
            ref_tmr_q <= ref_tmr_q - TW'(1);
         if (ref_req) begin
            ref_pend_q <= 1'b1;
            ref_user_q <= 1'b1;
         end else if (calib_q && ref_tmr_q == '0) begin
            ref_pend_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE, ST_EXEC: begin
               if (ref_pend_q) begin
                  state_q   <= ST_REFRESH;
                  ref_cnt_q <= SW'(REF_CYCLES - 1);
               end else if (!cq_empty) begin
                  state_q <= ST_EXEC;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_REFRESH: begin
               if (ref_cnt_q != '0)
                  ref_cnt_q <= ref_cnt_q - SW'(1);
               if (ref_cnt_q == SW'(1))
                  ref_ack_q <= ref_user_q || ref_req;
               // A request landing on the final stall cycle opens a fresh refresh.
               if (ref_cnt_q == '0) begin
                  state_q    <= ST_IDLE;
                  ref_tmr_q  <= TW'(REF_INTERVAL);
                  ref_pend_q <= ref_req;
                  ref_user_q <= ref_req;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else if (cq_push && !cmd_legal(cmd))
         err_q <= 1'b1;
   end

   logic [DATA_W-1:0] mem_q [2**MEM_AW];
   logic [DATA_W-1:0] ram_rd_q;

   always_ff @(posedge clk) begin
      if (dq_pop) begin
         for (int b = 0; b < BE_W; b++)
            if (!dq_mask[b])
               mem_q[mem_idx][b*8 +: 8] <= dq_data[b*8 +: 8];
      end
      if (rd_launch)
         ram_rd_q <= mem_q[mem_idx];
   end

   logic [RD_LAT-1:0] vld_q;
   logic [DATA_W-1:0] dat_q [1:RD_LAT-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 1; i < RD_LAT; i++)
            dat_q[i] <= '0;
      end else begin
         vld_q    <= {vld_q[RD_LAT-2:0], rd_launch};
         dat_q[1] <= ram_rd_q;
         for (int i = 2; i < RD_LAT; i++)
            dat_q[i] <= dat_q[i-1];
      end
   end

   assign rd_data             = dat_q[RD_LAT-1];
   assign rd_data_valid       = vld_q[RD_LAT-1];
   assign rd_data_end         = vld_q[RD_LAT-1];
   assign ref_ack             = ref_ack_q;
   assign init_calib_complete = calib_q;
   assign err_illegal         = err_q;

   logic unused_bits;
   assign unused_bits = ^{wr_data_end, cq_addr[ADDR_W-1:MEM_AW+3], cq_addr[2:0]};

endmodule

// File: doc/ddr3_app_responder.md
Name: ddr3_app_responder

Overview:
- Synthesizable responder for the DDR3 controller user (app) interface: cmd/addr/write-data in, read data out, backed by on-chip block RAM.
- Stands in for the DDR3 memory controller so ddr3_test and other app-side initiators can be brought up and regressed without PHY, PLL or DRAM.
- Preserves controller-visible timing: calibration delay, ready back-pressure, periodic refresh stalls and fixed read latency.

Parameters:
- DATA_W, 256, app data width (one BL8 beat on a x32 bus).
- ADDR_W, 29, app address width.
- MEM_AW, 10, log2 of backing-RAM depth in beats.
- CALIB_CYCLES, 64, cycles from reset release to init_calib_complete.
- RD_LAT, 6, cycles from read-command execution to rd_data_valid; must be >= 2.
- REF_INTERVAL, 780, cycles between automatic refresh stalls.
- REF_CYCLES, 16, refresh stall length.

Ports:
- clk  in  1  app clock (the controller's clk_out domain).
- rst  in  1  asynchronous active-high reset.
- cmd  in  3  3'b000 write, 3'b001 read; other codes illegal.
- cmd_en  in  1  command valid.
- addr  in  ADDR_W  beat address, 8-column aligned.
- cmd_ready  out  1  command accepted when cmd_en && cmd_ready.
- wr_data  in  DATA_W  write beat.
- wr_data_en  in  1  write data valid.
- wr_data_end  in  1  last beat; always 1 for BL8.
- wr_data_mask  in  DATA_W/8  1 = byte not written.
- wr_data_rdy  out  1  data accepted when wr_data_en && wr_data_rdy.
- rd_data  out  DATA_W  read beat.
- rd_data_valid  out  1  rd_data valid.
- rd_data_end  out  1  equals rd_data_valid.
- ref_req  in  1  user refresh request (pulse).
- ref_ack  out  1  one-cycle pulse at the end of a user refresh.
- init_calib_complete  out  1  interface ready.
- err_illegal  out  1  sticky flag: illegal cmd code was accepted.

Behaviour:
- Reset (async assert, sync release): every output 0; FIFOs empty; calib counter cleared; read pipeline flushed. In-flight reads are discarded and produce no rd_data_valid. RAM contents are undefined after reset.
- Calibration: init_calib_complete rises exactly CALIB_CYCLES clocks after rst deasserts and stays 1 until the next reset. Before that, cmd_ready and wr_data_rdy are 0.
- Command FIFO, 4 entries of {cmd, addr}:
  - cmd_ready = calib && !full && !refresh_stall.
  - An illegal code is accepted, sets err_illegal, and is dropped at execution.
- Write-data FIFO, 4 entries of {data, mask}:
  - wr_data_rdy = calib && !full.
  - Data may arrive before or after its command. Pairing is strictly FIFO order.
  - wr_data_end is ignored.
- Executor: single in-order engine.
  - States: IDLE, EXEC, REFRESH.
  - IDLE -> REFRESH when a refresh is pending; this has priority over a waiting command.
  - IDLE -> EXEC when the command FIFO is non-empty.
  - Write executes only when the data FIFO is non-empty; it pops both, then writes the RAM at index addr[MEM_AW+2:3] with per-byte enables = ~mask. Address bits above that index are ignored (aliasing).
  - Read pops the command and launches a RAM read. rd_data_valid = rd_data_end = 1 exactly RD_LAT cycles later, for one cycle.
  - Throughput: one command per cycle. Back-to-back reads give back-to-back valid beats.
  - Read-after-write to the same address returns the new data, because execution is in order.
- Refresh:
  - An interval counter reloads with REF_INTERVAL. On expiry, or on a ref_req pulse, refresh_pending is set.
  - The REFRESH state holds cmd_ready = 0 for REF_CYCLES cycles, then returns to IDLE and reloads the counter.
  - ref_ack pulses on the final REFRESH cycle only if the refresh was user-requested.
  - A ref_req during REFRESH is merged into the current refresh.
  - Reads already in the pipeline still complete during REFRESH.
- Simultaneous push and pop on a full FIFO is allowed. Push while full never occurs, because ready is low.

Decomposition:
- Shared package ddr3_app_pkg:
  - CMD_WR = 3'b000, CMD_RD = 3'b001.
  - Default DATA_W and ADDR_W.
  - Executor state enum.
- Sub-module app_sync_fifo (parameterised width/depth, full/empty flags), instantiated twice.
- Backing RAM is inferred inside the top module.

Test Plan:
- Calibration timing: release rst -> init_calib_complete rises exactly 64 cycles later; ready signals stay 0 before that.
- Write then read: write addr 0x08 with data {8{32'hA5A5_0001}}, mask 0; read 0x08 -> one valid beat with matching data, 6 cycles after execution.
- Byte mask: write all-ones, then all-zeros with mask 32'h0000_000F; read -> low 4 bytes FF, remaining bytes 00.
- Back-pressure: 4 write commands with no data -> cmd_ready drops on the 5th. Supply 4 data beats -> the writes complete and cmd_ready returns to 1.
- Refresh: pulse ref_req while idle -> cmd_ready low for 16 cycles, then ref_ack pulses once. An automatic refresh occurs every 780 cycles without ref_ack.
- Reset mid-read: issue 3 reads, assert rst 2 cycles later -> no rd_data_valid afterward, and all outputs are 0 during reset.
